// File: rtl/pwm_ctrl.sv
// pwm_ctrl: PWM control unit; shadow-registered config handshake, datapath strobe sequencing, registered PWM output
// Ports: clk, reset (sync, active-high); enable (run request); cfg_valid/cfg_ready/cfg_period/cfg_active/cfg_err
// (config handshake); isEq0/isEq1 (datapath flags in); periodIn/activeIn/loadReg/loadCNT (datapath controls out);
// pwm_out (waveform); running (high in RUN). Define PWM_CFG_CHECK_EN to reject period < 2 or active >= period.
module pwm_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_active,
  output logic         cfg_err,
  input  logic         isEq0,
  input  logic         isEq1,
  output logic [W-1:0] periodIn,
  output logic [W-1:0] activeIn,
  output logic         loadReg,
  output logic         loadCNT,
  output logic         pwm_out,
  output logic         running
);
  typedef enum logic [1:0] {IDLE, LOADREG, LOADCNT, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] period_q, period_d, active_q, active_d;
  logic pending_q, pending_d, have_cfg_q, have_cfg_d, pwm_q, pwm_d, err_q, err_d;
  logic cfg_fire, cfg_ok, cfg_take;
  assign cfg_fire = cfg_valid && cfg_ready;
`ifdef PWM_CFG_CHECK_EN
  assign cfg_ok = (cfg_period >= W'(2)) && (cfg_active < cfg_period);
`else
  assign cfg_ok = 1'b1;
`endif
  assign cfg_take = cfg_fire && cfg_ok;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (enable && (pending_q || have_cfg_q)) ? LOADREG : IDLE;
      LOADREG: state_d = LOADCNT;
      LOADCNT: state_d = RUN;
      RUN:     state_d = !isEq0 ? RUN : !enable ? IDLE : pending_q ? LOADREG : LOADCNT;
      default: state_d = IDLE;
    endcase
    // a config accepted during the LOADREG cycle itself stays pending: the datapath latched the old shadow
    pending_d  = cfg_take || (pending_q && state_q != LOADREG);
    have_cfg_d = have_cfg_q || state_q == LOADREG;
    period_d   = cfg_take ? cfg_period : period_q;
    active_d   = cfg_take ? cfg_active : active_q;
    // isEq0 wins over isEq1 so active == 0 yields 0% duty
    pwm_d      = state_q == RUN && !isEq0 && (isEq1 || pwm_q);
    err_d      = cfg_fire && !cfg_ok;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      period_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      have_cfg_q <= 1'b0;
      pwm_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      have_cfg_q <= have_cfg_d;
      pwm_q      <= pwm_d;
      err_q      <= err_d;
    end
  end
  assign cfg_ready = !pending_q;
  assign cfg_err   = err_q;
  assign periodIn  = period_q;
  assign activeIn  = active_q;
  assign loadReg   = state_q == LOADREG;
  assign loadCNT   = state_q == LOADCNT;
  assign pwm_out   = pwm_q;
  assign running   = state_q == RUN;
endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: self-checking bench for pwm_ctrl with a behavioural counter datapath and a config scoreboard
module tb_pwm_ctrl;
  localparam int W = 16;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0, cfg_active = '0;
  logic cfg_ready, cfg_err, isEq0, isEq1, loadReg, loadCNT, pwm_out, running;
  logic [W-1:0] periodIn, activeIn;
  int checks = 0, errors = 0;
  logic [2*W-1:0] sb[$];
  logic [W-1:0] dp_per = '0, dp_act = '0, cnt = '0;
  logic exp_run = 1'b0, prev_lr = 1'b0, chk_on = 1'b0;

  always #5 clk = ~clk;

  pwm_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_active(cfg_active), .cfg_err(cfg_err), .isEq0(isEq0), .isEq1(isEq1),
    .periodIn(periodIn), .activeIn(activeIn), .loadReg(loadReg), .loadCNT(loadCNT),
    .pwm_out(pwm_out), .running(running)
  );

  // datapath stand-in: registers latched on loadReg, down-counter reloaded with period-1 on loadCNT
  assign isEq0 = cnt == '0;
  assign isEq1 = cnt == dp_act;
  always @(posedge clk) begin
    if (loadReg) begin
      dp_per <= periodIn;
      dp_act <= activeIn;
    end
    if (loadCNT) cnt <= dp_per - 1'b1;
    else if (exp_run && cnt != '0) cnt <= cnt - 1'b1;
    exp_run <= reset ? 1'b0 : loadCNT ? 1'b1 : (exp_run && cnt == '0) ? 1'b0 : exp_run;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check_cycle();
    logic exp_pwm;
    logic [2*W-1:0] e;
    exp_pwm = exp_run && (cnt < dp_act);
    checks++;
    if (loadReg && loadCNT) begin errors++; $display("FAIL strobe_overlap: loadReg and loadCNT both high"); end
    checks++;
    if (running !== exp_run) begin errors++; $display("FAIL running: got %b want %b", running, exp_run); end
    checks++;
    if (pwm_out !== exp_pwm) begin errors++; $display("FAIL pwm_out: got %b want %b (cnt=%0d act=%0d)", pwm_out, exp_pwm, cnt, dp_act); end
    if (prev_lr) begin
      checks++;
      if (loadCNT !== 1'b1) begin errors++; $display("FAIL loadcnt_after_loadreg: got %b want 1", loadCNT); end
    end
    if (loadReg === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL unexpected_loadreg: periodIn=%0d activeIn=%0d with nothing expected", periodIn, activeIn);
      end else begin
        e = sb.pop_front();
        if ({periodIn, activeIn} !== e) begin
          errors++; $display("FAIL loadreg_values: got %0d/%0d want %0d/%0d", periodIn, activeIn, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
    prev_lr = (loadReg === 1'b1);
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_on) check_cycle();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cfg_valid = 1'b0;
    cycle();
    cycle();
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic send_cfg(input logic [W-1:0] p, input logic [W-1:0] a);
    logic ok;
    logic [W-1:0] old_p;
`ifdef PWM_CFG_CHECK_EN
    ok = (p >= 2) && (a < p);
`else
    ok = 1'b1;
`endif
    cfg_period = p;
    cfg_active = a;
    cfg_valid = 1'b1;
    for (int i = 0; i < 300 && cfg_ready !== 1'b1; i++) cycle();
    if (cfg_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: cfg_ready got %b want 1", cfg_ready);
      cfg_valid = 1'b0;
      return;
    end
    old_p = periodIn;
    if (ok) sb.push_back({p, a});
    cycle();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_err !== !ok) begin errors++; $display("FAIL cfg_err_pulse: got %b want %b", cfg_err, !ok); end
    checks++;
    if (cfg_ready !== !ok) begin errors++; $display("FAIL cfg_ready_after: got %b want %b", cfg_ready, !ok); end
    checks++;
    if (periodIn !== (ok ? p : old_p)) begin errors++; $display("FAIL shadow_period: got %0d want %0d", periodIn, ok ? p : old_p); end
    cycle();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_width: got %b want 0", cfg_err); end
  endtask

  task automatic wait_sb_empty(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) cycle();
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL loadreg_timeout: %0d configs never loaded, want 0", sb.size());
    end
    cycle();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 8;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    if (loadReg !== 1'b0) begin errors++; $display("FAIL reset_loadreg: got %b want 0", loadReg); end
    if (loadCNT !== 1'b0) begin errors++; $display("FAIL reset_loadcnt: got %b want 0", loadCNT); end
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    if (periodIn !== '0) begin errors++; $display("FAIL reset_period: got %0d want 0", periodIn); end
    if (activeIn !== '0) begin errors++; $display("FAIL reset_active: got %0d want 0", activeIn); end
    chk_on = 1'b1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    enable = 1'b1;
    send_cfg(10, 4);
    wait_sb_empty(20);
    cycle();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL basic_running: got %b want 1", running); end
    run_cycles(35);
  endtask

  task automatic test_reconfig();
    run_cycles(3);
    send_cfg(20, 15);
    wait_sb_empty(40);
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reconfig_ready: got %b want 1", cfg_ready); end
    run_cycles(50);
  endtask

  task automatic test_invalid();
    enable = 1'b0;
    apply_reset();
    send_cfg(5, 5);
    apply_reset();
    send_cfg(1, 0);
    enable = 1'b1;
    run_cycles(6);
    apply_reset();
  endtask

  task automatic test_zero_duty();
    int highs;
    highs = 0;
    send_cfg(8, 0);
    wait_sb_empty(20);
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (pwm_out !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL zero_duty: pwm_out high %0d cycles, want 0", highs); end
  endtask

  task automatic test_disable();
    send_cfg(10, 4);
    wait_sb_empty(30);
    for (int i = 0; i < 40 && !(exp_run && cnt == 2); i++) cycle();
    enable = 1'b0;
    for (int i = 0; i < 40 && exp_run; i++) cycle();
    checks++;
    if (exp_run) begin errors++; $display("FAIL disable_timeout: frame did not end, want stop"); end
    repeat (5) begin
      cycle();
      checks++;
      if (loadCNT !== 1'b0 || loadReg !== 1'b0 || running !== 1'b0 || pwm_out !== 1'b0) begin
        errors++;
        $display("FAIL disable_idle: loadCNT=%b loadReg=%b running=%b pwm=%b want all 0", loadCNT, loadReg, running, pwm_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back({16'd10, 16'd4});
    enable = 1'b1;
    wait_sb_empty(10);
    run_cycles(5);
    send_cfg(6, 2);
    send_cfg(9, 5);
    wait_sb_empty(60);
    run_cycles(25);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_cfg(10, 4);
    for (int i = 0; i < 20 && loadCNT !== 1'b1; i++) cycle();
    reset = 1'b1;
    cycle();
    checks += 8;
    if (loadCNT !== 1'b0) begin errors++; $display("FAIL abort_loadcnt: got %b want 0", loadCNT); end
    if (loadReg !== 1'b0) begin errors++; $display("FAIL abort_loadreg: got %b want 0", loadReg); end
    if (running !== 1'b0) begin errors++; $display("FAIL abort_running: got %b want 0", running); end
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL abort_pwm: got %b want 0", pwm_out); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", cfg_ready); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", cfg_err); end
    if (periodIn !== '0) begin errors++; $display("FAIL abort_period: got %0d want 0", periodIn); end
    if (activeIn !== '0) begin errors++; $display("FAIL abort_active: got %0d want 0", activeIn); end
    reset = 1'b0;
    run_cycles(8);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL abort_no_restart: running got %b want 0", running); end
    send_cfg(12, 3);
    wait_sb_empty(20);
    run_cycles(15);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reconfig();
    test_invalid();
    test_zero_duty();
    test_disable();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
